// File: rtl/next_pc_gen.sv
// next_pc_gen
//   Next-address generator for the fetch stage. It takes the PC held in
//   pc_reg (currentInst) and drives the address that pc_reg loads on the
//   next clock (nextInst). It handles the imem request/ready handshake,
//   sequential stepping, taken branches, jumps and decode stalls. After a
//   redirect it raises flush for FLUSH_CYCLES cycles so that wrong-path
//   fetches are killed in IF/ID.
//
// Ports
//   clk          in   1       single clock, rising edge
//   rst          in   1       synchronous, active-high reset
//   currentInst  in   ADDR_W  PC held in pc_reg
//   nextInst     out  ADDR_W  next PC, registered by pc_reg each clk
//   imemReq      out  1       fetch request to instruction memory
//   imemReady    in   1       imem accepts/returns fetch of currentInst
//   stall        in   1       hazard stall from decode; freeze PC
//   branchTaken  in   1       resolved taken branch
//   branchOffset in   ADDR_W  signed offset, in instructions
//   jump         in   1       unconditional jump
//   jumpTarget   in   ADDR_W  absolute jump address (bit 0 forced to 0)
//   flush        out  1       kill wrong-path instruction in IF/ID
//   fetchValid   out  1       registered: fetched word valid for decode
//   misalign     out  1       only with NEXT_PC_ALIGN_CHECK_EN: sticky flag,
//                             set by a taken jump to an odd target
//
// Build option
//   NEXT_PC_ALIGN_CHECK_EN : adds the misalign output. Without it the port
//                            is absent and jumpTarget[0] is silently dropped.

module next_pc_gen #(
   parameter int unsigned        ADDR_W       = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
   parameter int unsigned        INST_BYTES   = 2,
   parameter int unsigned        FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] currentInst,
   output logic [ADDR_W-1:0] nextInst,
   output logic              imemReq,
   input  logic              imemReady,
   input  logic              stall,
   input  logic              branchTaken,
   input  logic [ADDR_W-1:0] branchOffset,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jumpTarget,
   output logic              flush,
   output logic              fetchValid
`ifdef NEXT_PC_ALIGN_CHECK_EN
   ,
   output logic              misalign
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_REDIRECT
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [2:0]   r_flush_cnt;
   logic [2:0]   w_flush_cnt_nxt;
   logic         r_fetch_valid;
   logic         w_accept;
   logic         w_in_fetch;
   logic         w_redirect;
   logic [ADDR_W-1:0] w_seq_pc;
   logic [ADDR_W-1:0] w_br_pc;
   logic [ADDR_W-1:0] w_jmp_pc;

   assign fetchValid = r_fetch_valid;

   always_comb begin
      w_accept   = imemReady & ~stall;
      w_in_fetch = (r_state == S_FETCH);
      // Branch/jump only redirect from FETCH; in REDIRECT they come from
      // wrong-path instructions and are ignored.
      w_redirect = w_accept & w_in_fetch & (jump | branchTaken);
      w_seq_pc   = currentInst + ADDR_W'(INST_BYTES);
      w_br_pc    = w_seq_pc + (branchOffset << 1);
      w_jmp_pc   = jumpTarget & ~ADDR_W'(1);
   end

   // Next-state and outputs
   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      nextInst        = RESET_PC;
      imemReq         = 1'b0;
      flush           = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imemReq = ~rst;
            if (!w_accept)
               nextInst = currentInst;
            else if (jump)
               nextInst = w_jmp_pc;
            else if (branchTaken)
               nextInst = w_br_pc;
            else
               nextInst = w_seq_pc;
            if (w_redirect) begin
               w_state_nxt     = S_REDIRECT;
               w_flush_cnt_nxt = 3'(FLUSH_CYCLES);
            end
         end
         S_REDIRECT: begin
            imemReq  = ~rst;
            flush    = ~rst;
            nextInst = w_accept ? w_seq_pc : currentInst;
            // Counter runs regardless of stall
            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            if (r_flush_cnt == 3'd1)
               w_state_nxt = S_FETCH;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (rst)
         nextInst = RESET_PC;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_flush_cnt   <= '0;
         r_fetch_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_flush_cnt   <= w_flush_cnt_nxt;
         r_fetch_valid <= w_accept & w_in_fetch & ~jump & ~branchTaken;
      end
   end

`ifdef NEXT_PC_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         misalign <= 1'b0;
      else if (w_accept & w_in_fetch & jump & jumpTarget[0])
         misalign <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_next_pc_gen.sv
module tb_next_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] currentInst;
   logic [15:0] nextInst;
   logic        imemReq;
   logic        imemReady;
   logic        stall;
   logic        branchTaken;
   logic [15:0] branchOffset;
   logic        jump;
   logic [15:0] jumpTarget;
   logic        flush;
   logic        fetchValid;
`ifdef NEXT_PC_ALIGN_CHECK_EN
   logic        misalign;
`endif

   always #5 clk = ~clk;

   next_pc_gen #(
      .ADDR_W       (16),
      .RESET_PC     (16'h0000),
      .INST_BYTES   (2),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .currentInst  (currentInst),
      .nextInst     (nextInst),
      .imemReq      (imemReq),
      .imemReady    (imemReady),
      .stall        (stall),
      .branchTaken  (branchTaken),
      .branchOffset (branchOffset),
      .jump         (jump),
      .jumpTarget   (jumpTarget),
      .flush        (flush),
      .fetchValid   (fetchValid)
`ifdef NEXT_PC_ALIGN_CHECK_EN
      ,
      .misalign     (misalign)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Reference model: "started" = left reset/idle, flush_left = remaining
   // wrong-path cycles after a redirect (0 means normal fetching).
   bit          m_started;
   int          m_flush_left;
   bit          m_fv;
   bit          m_mis;
   logic [15:0] m_next;
   bit          m_req;
   bit          m_flush;

   // Values seen in the last cycle, for directed literal checks
   logic [15:0] o_next;
   logic        o_req;
   logic        o_flush;
   logic        o_fv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_comb();
      bit acc;
      bit fetching;
      int t;
      acc      = imemReady && !stall;
      fetching = (m_flush_left == 0);
      if (rst || !m_started) begin
         m_next  = 16'h0000;
         m_req   = 1'b0;
         m_flush = 1'b0;
      end else begin
         m_req   = 1'b1;
         m_flush = !fetching;
         if (!acc)
            m_next = currentInst;
         else if (fetching && jump)
            m_next = jumpTarget & 16'hFFFE;
         else if (fetching && branchTaken) begin
            t = int'(currentInst) + 2 + 2 * int'($signed(branchOffset));
            m_next = t[15:0];
         end else begin
            t = int'(currentInst) + 2;
            m_next = t[15:0];
         end
      end
   endtask

   task automatic model_seq();
      bit acc;
      bit fetching;
      acc      = imemReady && !stall;
      fetching = (m_flush_left == 0);
      if (rst) begin
         m_started    = 1'b0;
         m_flush_left = 0;
         m_fv         = 1'b0;
         m_mis        = 1'b0;
      end else if (!m_started) begin
         m_started = 1'b1;
         m_fv      = 1'b0;
      end else begin
         m_fv = acc && fetching && !jump && !branchTaken;
         if (acc && fetching && jump && jumpTarget[0])
            m_mis = 1'b1;
         if (!fetching)
            m_flush_left--;
         else if (acc && (jump || branchTaken))
            m_flush_left = 2;
      end
   endtask

   // One clock: inputs already driven after negedge. If follow is set the
   // bench acts as pc_reg and loads the model's next PC.
   task automatic cycle(input bit follow);
      #1;
      model_comb();
      o_next  = nextInst;
      o_req   = imemReq;
      o_flush = flush;
      o_fv    = fetchValid;
      check("nextInst",   32'(nextInst),   32'(m_next));
      check("imemReq",    32'(imemReq),    32'(m_req));
      check("flush",      32'(flush),      32'(m_flush));
      check("fetchValid", 32'(fetchValid), 32'(m_fv));
`ifdef NEXT_PC_ALIGN_CHECK_EN
      check("misalign",   32'(misalign),   32'(m_mis));
`endif
      @(posedge clk);
      model_seq();
      #1;
      if (follow)
         currentInst = m_next;
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      imemReady    = 1'b0;
      stall        = 1'b0;
      branchTaken  = 1'b0;
      branchOffset = 16'h0000;
      jump         = 1'b0;
      jumpTarget   = 16'h0000;
      currentInst  = 16'h0000;
      m_started    = 1'b0;
      m_flush_left = 0;
      m_fv         = 1'b0;
      m_mis        = 1'b0;
      @(posedge clk);
      model_seq();
      @(negedge clk);

      // Reset held two cycles
      cycle(0);
      check("rst_next", 32'(o_next), 32'h0000);
      check("rst_req",  32'(o_req),  32'h0);
      cycle(0);
      check("rst_fv",    32'(o_fv),    32'h0);
      check("rst_flush", 32'(o_flush), 32'h0);

      // Release: IDLE then sequential fetch
      rst       = 1'b0;
      imemReady = 1'b1;
      cycle(1);
      check("idle_next", 32'(o_next), 32'h0000);
      check("idle_req",  32'(o_req),  32'h0);
      cycle(1);
      check("seq_0002", 32'(o_next), 32'h0002);
      check("seq_req",  32'(o_req),  32'h1);
      cycle(1);
      check("seq_0004", 32'(o_next), 32'h0004);
      cycle(1);
      check("seq_0006", 32'(o_next), 32'h0006);

      // imem not ready: PC held
      currentInst = 16'h0010;
      imemReady   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(0);
         check("hold_next", 32'(o_next), 32'h0010);
         if (i > 0)
            check("hold_fv", 32'(o_fv), 32'h0);
      end

      // Backward branch and two flush cycles
      imemReady    = 1'b1;
      currentInst  = 16'h0020;
      branchTaken  = 1'b1;
      branchOffset = 16'hFFFC;
      cycle(1);
      check("br_next",  32'(o_next),  32'h001A);
      check("br_flush", 32'(o_flush), 32'h0);
      branchTaken = 1'b0;
      cycle(1);
      check("br_flush1", 32'(o_flush), 32'h1);
      cycle(1);
      check("br_flush2", 32'(o_flush), 32'h1);
      cycle(1);
      check("br_flush3", 32'(o_flush), 32'h0);

      // Jump beats branch, odd target
      jump        = 1'b1;
      jumpTarget  = 16'h1235;
      branchTaken = 1'b1;
      cycle(1);
      check("jmp_next", 32'(o_next), 32'h1234);
      jump        = 1'b0;
      branchTaken = 1'b0;
      cycle(1);
`ifdef NEXT_PC_ALIGN_CHECK_EN
      check("misalign_set", 32'(misalign), 32'h1);
`endif
      cycle(1);
      cycle(1);

      // Wrap at top of address space
      currentInst = 16'hFFFE;
      cycle(0);
      check("wrap_next", 32'(o_next), 32'h0000);

      // Stall with jump: held, then jump after release
      currentInst = 16'h0100;
      stall       = 1'b1;
      jump        = 1'b1;
      jumpTarget  = 16'h4000;
      cycle(0);
      check("stall_next",  32'(o_next),  32'h0100);
      check("stall_flush", 32'(o_flush), 32'h0);
      stall = 1'b0;
      cycle(1);
      check("rel_next", 32'(o_next), 32'h4000);
      jump = 1'b0;
      cycle(1);
      check("redir_flush", 32'(o_flush), 32'h1);

      // Reset during REDIRECT
      rst = 1'b1;
      cycle(1);
      check("rstr_next",  32'(o_next),  32'h0000);
      check("rstr_flush", 32'(o_flush), 32'h0);
      rst = 1'b0;
      cycle(1);
      check("post_flush", 32'(o_flush), 32'h0);
      check("post_fv",    32'(o_fv),    32'h0);
      check("post_next",  32'(o_next),  32'h0000);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst          = ($urandom_range(0, 99) < 2);
         imemReady    = ($urandom_range(0, 99) < 75);
         stall        = ($urandom_range(0, 99) < 20);
         branchTaken  = ($urandom_range(0, 99) < 15);
         jump         = ($urandom_range(0, 99) < 10);
         branchOffset = 16'($urandom);
         jumpTarget   = 16'($urandom);
         if ($urandom_range(0, 99) < 5)
            currentInst = 16'($urandom) & 16'hFFFE;
         cycle(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
